txn_sequencer: RTL and testbench
================================

# txn_sequencer

Parametrised top-level control FSM for the coin-transfer game: sequences power-up table/memory initialisation, then repeatedly collects NUM_FIELDS operator-loaded fields, arms, launches a transaction, and pulses a timed reset to the datapath. It replaces the fixed three-field controller. It adds a configurable field count, cancel, transaction watchdog, programmable reset-pulse length and a completed-transaction counter. It sits between the board push-buttons (already debounced) and the datapath/animation FSMs.

## Interface
- NUM_FIELDS, 3: number of load steps per transaction (>=1); FI_W = max(1, clog2(NUM_FIELDS)).
- RESET_CYCLES, 4: cycles reset_others is held low (>=1).
- TIMEOUT_CYCLES, 0: transaction watchdog length in cycles; 0 disables it.
- CNT_W, 8: width of txn_count.
- clock  in  1  system clock; all state changes on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start_signal  in  1  active-high; leaves STARTUP, fires transaction from ARMED.
- load_signal  in  1  active-high load button; field captured while high.
- cancel_signal  in  1  active-high; aborts collection.
- done_table_init  in  1  table initialiser finished.
- finished_init  in  1  memory initialiser finished.
- finished_transaction  in  1  animation/transfer finished.
- random_init  out  1  high in INIT1.
- init_memory  out  1  high in INIT2.
- load_memory  out  1  high in IDLE (display balances).
- load_field  out  NUM_FIELDS  one-hot, bit field_index high in LOAD, else 0.
- field_index  out  FI_W  current field number.
- start_transaction  out  1  high in TRANSACTION.
- reset_others  out  1  active-low datapath reset, low in RESET_OTHERS.
- global_reset  out  1  active-low system reset, low in STARTUP.
- timed_out  out  1  sticky watchdog flag.
- txn_count  out  CNT_W  completed (non-timed-out) transactions.

## Operation
- States: STARTUP, INIT1, INIT2, RESET_OTHERS, IDLE, LOAD, WAIT, ARMED, TRANSACTION. Outputs are Moore-decoded from the registered state, plus the registered field_index, txn_count and timed_out.
- STARTUP -> INIT1 on start_signal.
- INIT1 -> INIT2 on done_table_init.
- INIT2 -> RESET_OTHERS on finished_init.
- IDLE -> LOAD on load_signal, with field_index = 0.
- LOAD holds while load_signal is high. On release: if field_index == NUM_FIELDS-1 -> ARMED, else -> WAIT with field_index+1.
- WAIT -> LOAD on load_signal.
- ARMED -> TRANSACTION on start_signal.
- TRANSACTION -> RESET_OTHERS on finished_transaction, with txn_count+1 (wraps mod 2^CNT_W). When TIMEOUT_CYCLES != 0 and the watchdog expires -> RESET_OTHERS with timed_out set and txn_count unchanged.
- RESET_OTHERS -> IDLE after RESET_CYCLES cycles; field_index is cleared on exit.
- cancel_signal in LOAD, WAIT or ARMED -> RESET_OTHERS. It takes priority over load_signal/start_signal in the same cycle. cancel is ignored in all other states.
- timed_out clears on the next entry to TRANSACTION.
- Illegal state encoding -> STARTUP.
- Reset (any time, including mid-transaction): state STARTUP, field_index 0, txn_count 0, timed_out 0.
  - Output values during reset: global_reset 0, reset_others 1, all other outputs 0.

## Timing
- Single clock domain; a one-cycle input pulse is sufficient for every transition. Each transition takes effect at the next rising edge; outputs change in that same cycle.
- RESET_OTHERS: a counter is zeroed on entry and reset_others is low for exactly RESET_CYCLES consecutive cycles. RESET_CYCLES = 1 gives a single-cycle pulse.
- Watchdog: a counter is 0 in the first TRANSACTION cycle. Expiry occurs when it equals TIMEOUT_CYCLES-1 and finished_transaction is low; start_transaction is then high for exactly TIMEOUT_CYCLES cycles.
- If finished_transaction and expiry coincide, success wins (count increments, timed_out stays 0).
- NUM_FIELDS = 1: LOAD release goes directly to ARMED; WAIT is never entered.
- load_field bit never asserts outside LOAD.

## Test plan
- Startup path: hold resetn low 3 cycles, then pulse start_signal, done_table_init, finished_init. Required response: global_reset low until start, random_init then init_memory each high ≥1 cycle, reset_others low exactly 4 cycles, then load_memory = 1.
- Three-field load (defaults): hold load_signal 2 cycles ×3 with gaps. Required response: load_field = 001, 010, 100 in turn; after the third release the state is ARMED; start_signal gives start_transaction = 1; finished_transaction gives txn_count = 1 and reset_others low 4 cycles.
- Watchdog (TIMEOUT_CYCLES = 16): never assert finished_transaction. Required response: start_transaction high exactly 16 cycles, then timed_out = 1 and txn_count unchanged; the next transaction start clears timed_out.
- Coincidence: finished_transaction asserted in the 16th transaction cycle. Required response: txn_count increments, timed_out = 0.
- Cancel: assert cancel_signal together with load_signal in WAIT at field_index 1. Required response: RESET_OTHERS entered, field_index = 0 back in IDLE, no load_field asserted.
- Async reset mid-TRANSACTION; separately CNT_W = 2 with 5 transactions. Required responses: immediate STARTUP outputs with txn_count = 0; txn_count wraps to 1 after 5 transactions.

Source files
------------

// File: rtl/txn_sequencer.sv
// Top-level control FSM for the coin-transfer game: power-up init, N-field load, arm, launch,
// then a timed active-low pulse to the datapath. Optional transaction watchdog and done counter.
module txn_sequencer #(
  parameter int NUM_FIELDS     = 3,
  parameter int RESET_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W          = 8,
  localparam int FI_W          = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start_signal,
  input  logic                  load_signal,
  input  logic                  cancel_signal,
  input  logic                  done_table_init,
  input  logic                  finished_init,
  input  logic                  finished_transaction,
  output logic                  random_init,
  output logic                  init_memory,
  output logic                  load_memory,
  output logic [NUM_FIELDS-1:0] load_field,
  output logic [FI_W-1:0]       field_index,
  output logic                  start_transaction,
  output logic                  reset_others,
  output logic                  global_reset,
  output logic                  timed_out,
  output logic [CNT_W-1:0]      txn_count
);

  localparam int RC_W = (RESET_CYCLES > 0) ? $clog2(RESET_CYCLES + 1) : 1;
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [FI_W-1:0] FI_LAST = FI_W'(NUM_FIELDS - 1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [3:0] {
    STARTUP      = 4'd0,
    INIT1        = 4'd1,
    INIT2        = 4'd2,
    RESET_OTHERS = 4'd3,
    IDLE         = 4'd4,
    LOAD         = 4'd5,
    WAIT         = 4'd6,
    ARMED        = 4'd7,
    TRANSACTION  = 4'd8
  } state_t;

  state_t          state, next_state;
  logic [RC_W-1:0] rc_cnt;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expire;

  // Success on the expiry cycle wins, so expiry requires finished_transaction low.
  assign wd_expire = WD_EN && (state == TRANSACTION) && (wd_cnt == WD_LAST) && !finished_transaction;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= STARTUP;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      STARTUP:      if (start_signal) next_state = INIT1;
      INIT1:        if (done_table_init) next_state = INIT2;
      INIT2:        if (finished_init) next_state = RESET_OTHERS;
      RESET_OTHERS: if (rc_cnt == RC_LAST) next_state = IDLE;
      IDLE:         if (load_signal) next_state = LOAD;
      LOAD: begin
        if (cancel_signal)     next_state = RESET_OTHERS;
        else if (!load_signal) next_state = (field_index == FI_LAST) ? ARMED : WAIT;
      end
      WAIT: begin
        if (cancel_signal)    next_state = RESET_OTHERS;
        else if (load_signal) next_state = LOAD;
      end
      ARMED: begin
        if (cancel_signal)     next_state = RESET_OTHERS;
        else if (start_signal) next_state = TRANSACTION;
      end
      TRANSACTION:  if (finished_transaction || wd_expire) next_state = RESET_OTHERS;
      default:      next_state = STARTUP;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rc_cnt      <= '0;
      wd_cnt      <= '0;
      field_index <= '0;
      txn_count   <= '0;
      timed_out   <= 1'b0;
    end else begin
      // Both counters sit at zero outside their state, so they start from zero on entry.
      rc_cnt <= (state == RESET_OTHERS) ? rc_cnt + 1'b1 : '0;
      wd_cnt <= (state == TRANSACTION)  ? wd_cnt + 1'b1 : '0;

      if (state == IDLE && next_state == LOAD)              field_index <= '0;
      else if (state == LOAD && next_state == WAIT)         field_index <= field_index + 1'b1;
      else if (state == RESET_OTHERS && next_state == IDLE) field_index <= '0;

      if (state == TRANSACTION && finished_transaction) txn_count <= txn_count + 1'b1;

      if (wd_expire)                                        timed_out <= 1'b1;
      else if (state == ARMED && next_state == TRANSACTION) timed_out <= 1'b0;
    end
  end

  always_comb begin
    random_init       = (state == INIT1);
    init_memory       = (state == INIT2);
    load_memory       = (state == IDLE);
    start_transaction = (state == TRANSACTION);
    reset_others      = (state != RESET_OTHERS);
    global_reset      = (state != STARTUP);
    load_field        = '0;
    if (state == LOAD) load_field = NUM_FIELDS'(1) << field_index;
  end

endmodule

// File: tb/tb_txn_sequencer.sv
// Directed bench for txn_sequencer: startup, 3-field load, watchdog, coincidence, cancel,
// async reset mid-transaction and counter wrap (CNT_W = 2).
module tb_txn_sequencer;

  logic       clock = 1'b0;
  logic       resetn;
  logic       start_signal, load_signal, cancel_signal;
  logic       done_table_init, finished_init, finished_transaction;
  logic       random_init, init_memory, load_memory;
  logic [2:0] load_field;
  logic [1:0] field_index;
  logic       start_transaction, reset_others, global_reset, timed_out;
  logic [1:0] txn_count;

  int vectors = 0;
  int miscompares = 0;

  txn_sequencer #(
    .NUM_FIELDS(3), .RESET_CYCLES(4), .TIMEOUT_CYCLES(16), .CNT_W(2)
  ) dut (
    .clock(clock), .resetn(resetn),
    .start_signal(start_signal), .load_signal(load_signal), .cancel_signal(cancel_signal),
    .done_table_init(done_table_init), .finished_init(finished_init),
    .finished_transaction(finished_transaction),
    .random_init(random_init), .init_memory(init_memory), .load_memory(load_memory),
    .load_field(load_field), .field_index(field_index),
    .start_transaction(start_transaction), .reset_others(reset_others),
    .global_reset(global_reset), .timed_out(timed_out), .txn_count(txn_count)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Called in the first RESET_OTHERS cycle; counts low cycles until release.
  task automatic count_ro(input string tag);
    int n = 0;
    while (reset_others == 1'b0 && n < 20) begin
      n++;
      tick();
    end
    chk(tag, n, 4);
  endtask

  task automatic boot;
    chk("gr_low_startup", 32'(global_reset), 0);
    tick();
    chk("gr_hold_startup", 32'(global_reset), 0);
    start_signal = 1'b1; tick(); start_signal = 1'b0;
    chk("gr_high_init1", 32'(global_reset), 1);
    chk("random_init", 32'(random_init), 1);
    done_table_init = 1'b1; tick(); done_table_init = 1'b0;
    chk("init_memory", 32'(init_memory), 1);
    chk("random_init_off", 32'(random_init), 0);
    finished_init = 1'b1; tick(); finished_init = 1'b0;
    chk("ro_low_boot", 32'(reset_others), 0);
    count_ro("ro_len_boot");
    chk("load_memory_idle", 32'(load_memory), 1);
  endtask

  // Three single-cycle load pulses from IDLE, ending in ARMED.
  task automatic load_all;
    for (int f = 0; f < 3; f++) begin
      load_signal = 1'b1; tick();
      load_signal = 1'b0; tick();
    end
  endtask

  task automatic fire;
    start_signal = 1'b1; tick(); start_signal = 1'b0;
  endtask

  initial begin
    int n;
    resetn = 1'b0;
    start_signal = 1'b0; load_signal = 1'b0; cancel_signal = 1'b0;
    done_table_init = 1'b0; finished_init = 1'b0; finished_transaction = 1'b0;
    repeat (3) tick();
    chk("rst_global_reset", 32'(global_reset), 0);
    chk("rst_reset_others", 32'(reset_others), 1);
    chk("rst_load_memory", 32'(load_memory), 0);
    chk("rst_txn_count", 32'(txn_count), 0);
    chk("rst_field_index", 32'(field_index), 0);
    resetn = 1'b1;
    boot();

    // Three-field load, each held two cycles with a gap.
    for (int f = 0; f < 3; f++) begin
      load_signal = 1'b1; tick();
      chk("ld_field", 32'(load_field), 1 << f);
      chk("ld_index", 32'(field_index), f);
      tick();
      chk("ld_field_hold", 32'(load_field), 1 << f);
      load_signal = 1'b0; tick();
      chk("ld_release", 32'(load_field), 0);
      tick();
    end
    chk("armed_start_txn", 32'(start_transaction), 0);
    chk("armed_load_memory", 32'(load_memory), 0);
    chk("armed_reset_others", 32'(reset_others), 1);
    chk("armed_index", 32'(field_index), 2);
    fire();
    chk("txn_start", 32'(start_transaction), 1);
    tick(); tick();
    finished_transaction = 1'b1; tick(); finished_transaction = 1'b0;
    chk("txn_count_1", 32'(txn_count), 1);
    chk("txn_ro_low", 32'(reset_others), 0);
    count_ro("ro_len_txn");

    // Watchdog expiry.
    load_all();
    fire();
    n = 0;
    while (start_transaction == 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("wd_txn_cycles", n, 16);
    chk("wd_timed_out", 32'(timed_out), 1);
    chk("wd_count_kept", 32'(txn_count), 1);
    count_ro("ro_len_wd");

    // Next start clears timed_out; finish lands on the expiry cycle.
    load_all();
    fire();
    chk("wd_clear", 32'(timed_out), 0);
    repeat (15) tick();
    chk("coin_still_txn", 32'(start_transaction), 1);
    finished_transaction = 1'b1; tick(); finished_transaction = 1'b0;
    chk("coin_count", 32'(txn_count), 2);
    chk("coin_timed_out", 32'(timed_out), 0);
    chk("coin_ro_low", 32'(reset_others), 0);
    count_ro("ro_len_coin");

    // Cancel with load in WAIT at field 1.
    load_signal = 1'b1; tick();
    load_signal = 1'b0; tick();
    chk("cxl_wait_index", 32'(field_index), 1);
    cancel_signal = 1'b1; load_signal = 1'b1; tick();
    cancel_signal = 1'b0; load_signal = 1'b0;
    chk("cxl_ro_low", 32'(reset_others), 0);
    chk("cxl_no_load_field", 32'(load_field), 0);
    count_ro("ro_len_cxl");
    chk("cxl_index_idle", 32'(field_index), 0);
    chk("cxl_idle", 32'(load_memory), 1);
    chk("cxl_count", 32'(txn_count), 2);

    // Asynchronous reset mid-transaction.
    load_all();
    fire();
    tick();
    #2 resetn = 1'b0;
    #1;
    chk("arst_global_reset", 32'(global_reset), 0);
    chk("arst_start_txn", 32'(start_transaction), 0);
    chk("arst_reset_others", 32'(reset_others), 1);
    chk("arst_txn_count", 32'(txn_count), 0);
    chk("arst_field_index", 32'(field_index), 0);
    tick(); tick();
    resetn = 1'b1;
    boot();

    // Five transactions on a 2-bit counter.
    for (int i = 1; i <= 5; i++) begin
      load_all();
      fire();
      finished_transaction = 1'b1; tick(); finished_transaction = 1'b0;
      if (i == 4) chk("wrap_zero", 32'(txn_count), 0);
      count_ro("ro_len_wrap");
    end
    chk("wrap_one", 32'(txn_count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
